// File: rtl/writeback_arbiter_pkg.sv
// Shared definitions for the writeback arbiter and the issue stage:
// functional-unit codes and round-robin helper.
package writeback_arbiter_pkg;

    typedef enum logic [1:0] {
        UNIT_AM   = 2'b00,
        UNIT_MEM  = 2'b01,
        UNIT_MUL  = 2'b10,
        UNIT_NONE = 2'b11
    } unit_e;

    localparam int NUM_UNITS  = 3;
    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;

    // Unit visited at position 'step' of a search that begins just after 'last'.
    function automatic logic [1:0] rr_candidate(input logic [1:0] last, input int step);
        int idx;
        idx = (int'(last) + 1 + step) % NUM_UNITS;
        return idx[1:0];
    endfunction

endpackage

// File: rtl/writeback_arbiter_wb_fifo.sv
// Per-unit result buffer: power-of-two circular FIFO with registered occupancy.
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];
    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/writeback_arbiter.sv
// Buffers AluMisc/Mem/Mult results and retires them one per cycle onto the
// ARF write port, clearing the matching scoreboard pending bit.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [2:0]            fu_wb_valid,
    output logic [2:0]            fu_wb_ready,
    input  logic [3*ADDR_W-1:0]   fu_wb_regdest,
    input  logic [2:0]            fu_wb_writereg,
    input  logic [2:0]            fu_wb_overflow,
    input  logic [3*DATA_W-1:0]   fu_wb_data,
    output logic                  wb_reg_write,
    output logic [ADDR_W-1:0]     wb_reg_addr,
    output logic [DATA_W-1:0]     wb_reg_data,
    output logic                  wb_sb_clear,
    output logic [ADDR_W-1:0]     wb_sb_addr,
    output logic [1:0]            wb_sb_unit,
    output logic                  wb_busy
);

    localparam int ENTRY_W = ADDR_W + 2 + DATA_W;
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    logic [ENTRY_W-1:0]   fifo_out [NUM_UNITS];
    logic [CNT_W-1:0]     count    [NUM_UNITS];
    logic [NUM_UNITS-1:0] push;
    logic [NUM_UNITS-1:0] pop;
    logic [NUM_UNITS-1:0] empty;
    logic [NUM_UNITS-1:0] full;

    logic                 pop_vld;
    logic [1:0]           pop_unit;
    logic [1:0]           cand;
    logic [1:0]           rr_last;

    logic                 vld_p0;
    logic [ENTRY_W-1:0]   entry_p0;
    logic [1:0]           unit_p0;

    logic [ADDR_W-1:0]    regdest_p0;
    logic                 writereg_p0;
    logic                 overflow_p0;
    logic [DATA_W-1:0]    data_p0;

    for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
        // Ready depends only on registered occupancy, so a full FIFO being
        // popped this cycle still refuses the new result.
        assign fu_wb_ready[u] = (count[u] != CNT_W'(DEPTH));
        assign push[u]        = fu_wb_valid[u] & ~full[u];
        assign pop[u]         = pop_vld && (pop_unit == 2'(u));

        wb_fifo #(
            .DEPTH (DEPTH),
            .WIDTH (ENTRY_W)
        ) u_fifo (
            .clock     (clock),
            .reset     (reset),
            .push      (push[u]),
            .push_data ({fu_wb_regdest[u*ADDR_W +: ADDR_W], fu_wb_writereg[u],
                         fu_wb_overflow[u], fu_wb_data[u*DATA_W +: DATA_W]}),
            .pop       (pop[u]),
            .pop_data  (fifo_out[u]),
            .count     (count[u]),
            .empty     (empty[u]),
            .full      (full[u])
        );
    end

    always_comb begin
        pop_vld  = 1'b0;
        pop_unit = 2'd0;
        cand     = 2'd0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            cand = rr_candidate(rr_last, k);
            if (!pop_vld && !empty[cand]) begin
                pop_vld  = 1'b1;
                pop_unit = cand;
            end
        end
    end

    // ---- stage p0: popped entry captured ----
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p0  <= 1'b0;
            rr_last <= 2'd2;
        end else begin
            vld_p0 <= pop_vld;
            if (pop_vld) rr_last <= pop_unit;
        end
    end

    always_ff @(posedge clock) begin
        if (pop_vld) begin
            entry_p0 <= fifo_out[pop_unit];
            unit_p0  <= pop_unit;
        end
    end

    assign regdest_p0  = entry_p0[ENTRY_W-1 -: ADDR_W];
    assign writereg_p0 = entry_p0[DATA_W+1];
    assign overflow_p0 = entry_p0[DATA_W];
    assign data_p0     = entry_p0[DATA_W-1:0];

    // ---- stage p1: ARF write and scoreboard clear ----
    // The pending bit is cleared even when the ARF write is suppressed,
    // because issue marked it pending regardless of overflow or r0.
    always_ff @(posedge clock) begin
        if (reset) begin
            wb_reg_write <= 1'b0;
            wb_sb_clear  <= 1'b0;
            wb_reg_addr  <= '0;
            wb_reg_data  <= '0;
            wb_sb_unit   <= UNIT_NONE;
        end else if (vld_p0) begin
            wb_sb_clear  <= writereg_p0;
            wb_reg_write <= writereg_p0 & ~overflow_p0 & (regdest_p0 != '0);
            wb_reg_addr  <= regdest_p0;
            wb_reg_data  <= data_p0;
            wb_sb_unit   <= unit_p0;
        end else begin
            wb_reg_write <= 1'b0;
            wb_sb_clear  <= 1'b0;
        end
    end

    assign wb_sb_addr = wb_reg_addr;
    assign wb_busy    = (~&empty) | vld_p0 | wb_reg_write | wb_sb_clear;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: vector table, directed sequences
// and a per-unit scoreboard fed at acceptance and drained at retirement.
module tb_writeback_arbiter;

    localparam int DEPTH  = 2;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic                clock;
    logic                reset;
    logic [2:0]          fu_wb_valid;
    logic [2:0]          fu_wb_ready;
    logic [3*ADDR_W-1:0] fu_wb_regdest;
    logic [2:0]          fu_wb_writereg;
    logic [2:0]          fu_wb_overflow;
    logic [3*DATA_W-1:0] fu_wb_data;
    logic                wb_reg_write;
    logic [ADDR_W-1:0]   wb_reg_addr;
    logic [DATA_W-1:0]   wb_reg_data;
    logic                wb_sb_clear;
    logic [ADDR_W-1:0]   wb_sb_addr;
    logic [1:0]          wb_sb_unit;
    logic                wb_busy;

    writeback_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clock          (clock),
        .reset          (reset),
        .fu_wb_valid    (fu_wb_valid),
        .fu_wb_ready    (fu_wb_ready),
        .fu_wb_regdest  (fu_wb_regdest),
        .fu_wb_writereg (fu_wb_writereg),
        .fu_wb_overflow (fu_wb_overflow),
        .fu_wb_data     (fu_wb_data),
        .wb_reg_write   (wb_reg_write),
        .wb_reg_addr    (wb_reg_addr),
        .wb_reg_data    (wb_reg_data),
        .wb_sb_clear    (wb_sb_clear),
        .wb_sb_addr     (wb_sb_addr),
        .wb_sb_unit     (wb_sb_unit),
        .wb_busy        (wb_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]        unit;
        logic [ADDR_W-1:0] rd;
        logic              wr;
        logic              ov;
        logic [DATA_W-1:0] data;
        logic              exp_write;
        logic              exp_clear;
    } vec_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              write;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic set_unit(input int u, input logic [ADDR_W-1:0] rd, input logic wr,
                            input logic ov, input logic [DATA_W-1:0] d);
        fu_wb_regdest[u*ADDR_W +: ADDR_W] = rd;
        fu_wb_writereg[u]                 = wr;
        fu_wb_overflow[u]                 = ov;
        fu_wb_data[u*DATA_W +: DATA_W]    = d;
    endtask

    task automatic push_exp(input int u, input logic [ADDR_W-1:0] rd, input logic wr,
                            input logic ov, input logic [DATA_W-1:0] d);
        exp_t e;
        if (wr) begin
            e.addr  = rd;
            e.data  = d;
            e.write = !ov && (rd != '0);
            case (u)
                0:       q0.push_back(e);
                1:       q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
    endtask

    // One clock: handshakes seen before the edge are recorded as expected retirements.
    task automatic step(output logic [2:0] acc);
        acc = reset ? 3'b000 : (fu_wb_valid & fu_wb_ready);
        @(posedge clock);
        for (int u = 0; u < 3; u++)
            if (acc[u])
                push_exp(u, fu_wb_regdest[u*ADDR_W +: ADDR_W], fu_wb_writereg[u],
                         fu_wb_overflow[u], fu_wb_data[u*DATA_W +: DATA_W]);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        fu_wb_valid = 3'b000;
        @(posedge clock);
        #1;
        q0.delete();
        q1.delete();
        q2.delete();
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Scoreboard: every clear strobe must match the oldest pending entry of its unit.
    always @(negedge clock) begin
        if (reset === 1'b0 && wb_reg_write === 1'b1)
            check("write_without_clear", 64'(wb_sb_clear), 64'(1));
        if (reset === 1'b0 && wb_sb_clear === 1'b1) begin
            exp_t e;
            logic got;
            got = 1'b0;
            case (wb_sb_unit)
                2'd0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
                2'd1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
                2'd2: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
                default: got = 1'b0;
            endcase
            checks++;
            if (!got) begin
                errors++;
                $display("FAIL sb_unexpected: clear for unit %0d addr %0d, expected no retirement",
                         wb_sb_unit, wb_reg_addr);
            end else if (wb_reg_addr !== e.addr || wb_sb_addr !== e.addr ||
                         wb_reg_data !== e.data || wb_reg_write !== e.write) begin
                errors++;
                $display("FAIL sb_entry: unit %0d got addr %0d data %h write %b, expected addr %0d data %h write %b",
                         wb_sb_unit, wb_reg_addr, wb_reg_data, wb_reg_write, e.addr, e.data, e.write);
            end
        end
    end

    task automatic run_row(input vec_t v, input int idx);
        logic [2:0] acc;
        int u;
        u = int'(v.unit);
        fu_wb_valid = 3'b000;
        set_unit(u, v.rd, v.wr, v.ov, v.data);
        fu_wb_valid[u] = 1'b1;
        step(acc);
        check($sformatf("row%0d_accept", idx), 64'(acc[u]), 64'(1));
        fu_wb_valid = 3'b000;
        step(acc);
        check($sformatf("row%0d_early", idx), 64'({wb_reg_write, wb_sb_clear}), 64'(0));
        step(acc);
        check($sformatf("row%0d_write", idx), 64'(wb_reg_write), 64'(v.exp_write));
        check($sformatf("row%0d_clear", idx), 64'(wb_sb_clear), 64'(v.exp_clear));
        check($sformatf("row%0d_addr", idx), 64'(wb_reg_addr), 64'(v.rd));
        check($sformatf("row%0d_sb_addr", idx), 64'(wb_sb_addr), 64'(v.rd));
        check($sformatf("row%0d_data", idx), 64'(wb_reg_data), 64'(v.data));
        check($sformatf("row%0d_unit", idx), 64'(wb_sb_unit), 64'(v.unit));
        step(acc);
        check($sformatf("row%0d_after", idx), 64'({wb_reg_write, wb_sb_clear}), 64'(0));
        check($sformatf("row%0d_idle_busy", idx), 64'(wb_busy), 64'(0));
    endtask

    vec_t vecs[6];

    initial begin
        logic [2:0] acc;
        int cnt[3];
        int waited;

        vecs[0] = '{unit: 2'd0, rd: 5'd5,  wr: 1'b1, ov: 1'b0, data: 32'hDEADBEEF, exp_write: 1'b1, exp_clear: 1'b1};
        vecs[1] = '{unit: 2'd2, rd: 5'd7,  wr: 1'b1, ov: 1'b1, data: 32'h0BADF00D, exp_write: 1'b0, exp_clear: 1'b1};
        vecs[2] = '{unit: 2'd1, rd: 5'd0,  wr: 1'b1, ov: 1'b0, data: 32'h11112222, exp_write: 1'b0, exp_clear: 1'b1};
        vecs[3] = '{unit: 2'd1, rd: 5'd9,  wr: 1'b0, ov: 1'b0, data: 32'h33334444, exp_write: 1'b0, exp_clear: 1'b0};
        vecs[4] = '{unit: 2'd2, rd: 5'd31, wr: 1'b1, ov: 1'b0, data: 32'h12345678, exp_write: 1'b1, exp_clear: 1'b1};
        vecs[5] = '{unit: 2'd1, rd: 5'd3,  wr: 1'b1, ov: 1'b0, data: 32'hCAFEF00D, exp_write: 1'b1, exp_clear: 1'b1};

        reset          = 1'b1;
        fu_wb_valid    = '0;
        fu_wb_regdest  = '0;
        fu_wb_writereg = '0;
        fu_wb_overflow = '0;
        fu_wb_data     = '0;

        // Reset state
        do_reset();
        check("rst_write", 64'(wb_reg_write), 64'(0));
        check("rst_clear", 64'(wb_sb_clear), 64'(0));
        check("rst_addr", 64'(wb_reg_addr), 64'(0));
        check("rst_sb_addr", 64'(wb_sb_addr), 64'(0));
        check("rst_data", 64'(wb_reg_data), 64'(0));
        check("rst_unit", 64'(wb_sb_unit), 64'(3));
        check("rst_busy", 64'(wb_busy), 64'(0));
        check("rst_ready", 64'(fu_wb_ready), 64'(3'b111));

        // Single results: latency, overflow, r0, store
        for (int i = 0; i < 6; i++) run_row(vecs[i], i);

        // Round robin from reset, with unit 0 refilled
        do_reset();
        set_unit(0, 5'd1, 1'b1, 1'b0, 32'hA0000001);
        set_unit(1, 5'd2, 1'b1, 1'b0, 32'hA0000002);
        set_unit(2, 5'd3, 1'b1, 1'b0, 32'hA0000003);
        fu_wb_valid = 3'b111;
        step(acc);
        check("rr_accept_all", 64'(acc), 64'(3'b111));
        fu_wb_valid = 3'b000;
        step(acc);
        check("rr_no_strobe_yet", 64'(wb_sb_clear), 64'(0));
        set_unit(0, 5'd4, 1'b1, 1'b0, 32'hA0000004);
        fu_wb_valid = 3'b001;
        step(acc);
        check("rr_first_unit", 64'(wb_sb_unit), 64'(0));
        check("rr_first_addr", 64'(wb_reg_addr), 64'(1));
        check("rr_first_clear", 64'(wb_sb_clear), 64'(1));
        fu_wb_valid = 3'b000;
        step(acc);
        check("rr_second_unit", 64'(wb_sb_unit), 64'(1));
        check("rr_second_addr", 64'(wb_reg_addr), 64'(2));
        step(acc);
        check("rr_third_unit", 64'(wb_sb_unit), 64'(2));
        check("rr_third_addr", 64'(wb_reg_addr), 64'(3));
        step(acc);
        check("rr_refill_unit", 64'(wb_sb_unit), 64'(0));
        check("rr_refill_addr", 64'(wb_reg_addr), 64'(4));
        check("rr_refill_write", 64'(wb_reg_write), 64'(1));
        step(acc);
        check("rr_done", 64'({wb_reg_write, wb_sb_clear}), 64'(0));

        // Backpressure: Mult held valid 4 cycles, AM/Mem streaming
        do_reset();
        cnt = '{0, 0, 0};
        for (int c = 0; c < 12; c++) begin
            fu_wb_valid = 3'b000;
            for (int u = 0; u < 3; u++) begin
                set_unit(u, 5'(1 + ((u * 8 + cnt[u]) % 31)), !(u == 0 && cnt[u] == 3),
                         (u == 2 && cnt[u] == 1), {8'(u + 8'hB0), 24'(cnt[u])});
            end
            if (c < 10) fu_wb_valid[1:0] = 2'b11;
            if (c < 4)  fu_wb_valid[2]   = 1'b1;
            step(acc);
            for (int u = 0; u < 3; u++) if (acc[u]) cnt[u]++;
            if (c == 1) check("mult_ready_drops", 64'(fu_wb_ready[2]), 64'(0));
        end
        fu_wb_valid = 3'b000;
        check("mult_accepts", 64'(cnt[2]), 64'(DEPTH));
        waited = 0;
        while (wb_busy !== 1'b0 && waited < 60) begin
            step(acc);
            waited++;
        end
        check("drain_timeout", 64'(wb_busy), 64'(0));
        check("drain_q_empty", 64'(q0.size() + q1.size() + q2.size()), 64'(0));

        // Reset with buffered results
        do_reset();
        fu_wb_valid = 3'b111;
        for (int c = 0; c < 4; c++) begin
            for (int u = 0; u < 3; u++)
                set_unit(u, 5'(10 + u * 4 + c), 1'b1, 1'b0, {8'hC0, 8'(u), 16'(c)});
            step(acc);
        end
        check("pre_reset_busy", 64'(wb_busy), 64'(1));
        do_reset();
        check("mid_rst_write", 64'(wb_reg_write), 64'(0));
        check("mid_rst_clear", 64'(wb_sb_clear), 64'(0));
        check("mid_rst_ready", 64'(fu_wb_ready), 64'(3'b111));
        check("mid_rst_busy", 64'(wb_busy), 64'(0));
        check("mid_rst_unit", 64'(wb_sb_unit), 64'(3));
        for (int c = 0; c < 3; c++) begin
            step(acc);
            check("post_rst_quiet", 64'({wb_reg_write, wb_sb_clear, wb_busy}), 64'(0));
        end
        run_row(vecs[4], 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors %0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Completion-side counterpart of the issue stage. Issue marks a destination register pending in the scoreboard when it dispatches an instruction. This block works at the other end of that protocol. It accepts results from the three functional units (AluMisc, Mem, Mult) through valid/ready handshakes and buffers them per unit. It serialises them onto the single ARF write port and emits the scoreboard clear that retires the pending entry.

## Interface
Parameters:
- DEPTH, 2: entries per unit result FIFO (power of two, ≥2)
- DATA_W, 32: result width
- ADDR_W, 5: register address width

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- fu_wb_valid  in  3  per-unit result valid; bit0 AluMisc, bit1 Mem, bit2 Mult
- fu_wb_ready  out  3  per-unit accept; a transfer occurs when valid&ready at a clock edge
- fu_wb_regdest  in  3*ADDR_W  destination register per unit, unit u at [u*ADDR_W +: ADDR_W]
- fu_wb_writereg  in  3  instruction writes a register (mirrors issue's writereg)
- fu_wb_overflow  in  3  result raised overflow under writeov; ARF write is suppressed
- fu_wb_data  in  3*DATA_W  result per unit
- wb_reg_write  out  1  ARF write enable
- wb_reg_addr  out  ADDR_W  ARF write address
- wb_reg_data  out  DATA_W  ARF write data
- wb_sb_clear  out  1  scoreboard pending-clear strobe
- wb_sb_addr  out  ADDR_W  register whose pending bit is cleared
- wb_sb_unit  out  2  unit code of the retiring instruction (00 AluMisc, 01 Mem, 10 Mult)
- wb_busy  out  1  any FIFO non-empty or an output strobe active

## Operation
- One FIFO per unit. Entry = {regdest, writereg, overflow, data}.
- fu_wb_ready[u] = (count[u] != DEPTH). It is computed from registered count only, never from valid or pop.
- Push and pop on the same FIFO in one cycle: allowed, count unchanged. A full FIFO popped this cycle still shows ready=0 this cycle.
- Arbitration: round-robin among non-empty FIFOs, search order starting at rr_last+1 mod 3. At most one pop per cycle. rr_last updates to the popped unit.
- Popped entry drives registered outputs on the next edge:
  - wb_sb_clear = writereg. Cleared even on overflow or regdest 0, because issue marked it pending.
  - wb_reg_write = writereg & ~overflow & (regdest != 0).
  - wb_sb_addr = wb_reg_addr = regdest; wb_reg_data = data; wb_sb_unit = unit index.
- No pop: wb_reg_write=0 and wb_sb_clear=0. Address, data and unit hold their last value.
- Entries with writereg=0 (stores) are still popped and consume one arbitration slot, with both strobes low.
- Within a unit, order is strict FIFO. Across units, no ordering is guaranteed; upstream WAW stalling guarantees no two in-flight writes share a destination.

## Timing
- Reset (synchronous, sampled at edge):
  - all counts 0, FIFO pointers 0, rr_last=2 (unit 0 wins first), fu_wb_ready=3'b111 from the following cycle
  - wb_reg_write=0, wb_sb_clear=0, wb_reg_addr=0, wb_reg_data=0, wb_sb_addr=0, wb_sb_unit=2'b11, wb_busy=0
- Reset mid-operation discards all buffered results and any strobe that would have fired at that edge.
- Latency: a result accepted at edge N is, at the earliest, popped during cycle N+1 and visible on the outputs after edge N+2. This holds when its FIFO was empty and it wins arbitration.
- Throughput: one retirement per cycle aggregate. With all three units streaming, each unit gets 1/3.
- Each accepted entry produces exactly one output cycle.

## Structure
- Shared package/header: unit codes (AM=2'b00, MEM=2'b01, MUL=2'b10, NONE=2'b11), NUM_UNITS=3, ADDR_W/DATA_W defaults. The issue stage uses the same codes.
- One sub-module: wb_fifo (DEPTH, WIDTH), instantiated three times. It has a synchronous active-high reset and outputs count/empty/full. The arbiter, rr_last and output registers live in the top.

## Test plan
- Single AluMisc result: regdest=5, data=0xDEADBEEF, writereg=1 accepted at edge 1. After edge 3: wb_reg_write=1, addr=5, data=0xDEADBEEF, wb_sb_clear=1, unit=00. Both strobes low the next cycle.
- All three units valid in the same cycle after reset, regdest 1/2/3. Retire order is unit 0, 1, 2 on consecutive cycles. Then unit 0 again if refilled.
- Overflow and r0: overflow=1 with regdest=7 gives wb_sb_clear=1, addr=7, wb_reg_write=0. Then regdest=0, writereg=1 gives clear=1, write=0. Store (writereg=0) gives both low.
- Backpressure: hold Mult valid for 4 cycles while AM and Mem stream continuously. Mult ready drops after DEPTH=2 accepts. No entry is lost or duplicated, and per-unit order is preserved (scoreboard model check).
- Reset with 2 entries in each FIFO: assert reset one cycle. No strobe fires at or after the reset edge, ready=3'b111, wb_busy=0, and the first post-reset result retires with normal latency.
